// File: rtl/tt_bridge_pkg.sv
// Shared definitions for the host byte bridge: FSM states, command layout, error flag indices.
// Build option: TT_BYTE_BRIDGE_TIMEOUT_EN widens the error vector to carry the timeout flag.
package tt_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_WAIT_WR,
    ST_RREQ,
    ST_RDATA
  } state_t;

  localparam int CMD_RD_BIT = 7;
  localparam int CMD_CH_MSB = 6;

  localparam int ERR_BADCH = 0;
  localparam int ERR_OVR   = 1;
  localparam int ERR_TMO   = 2;

`ifdef TT_BYTE_BRIDGE_TIMEOUT_EN
  localparam int ERR_W = 3;
`else
  localparam int ERR_W = 2;
`endif

endpackage

// File: rtl/tt_strobe_sync.sv
// Synchroniser for an asynchronous strobe followed by a rising-edge detector.
// The pulse output is high for one clk cycle per rising edge of async_in.
module tt_strobe_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      last_q <= sync_q[STAGES-1];
    end
  end

  assign pulse = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/tt_byte_bridge.sv
// Host pin to channel bridge: framed multi-byte reads and writes over NUM_CH channel registers.
// Build option: define TT_BYTE_BRIDGE_TIMEOUT_EN to abort stalled frames and add err[2].
module tt_byte_bridge
  import tt_bridge_pkg::*;
#(
  parameter int  DATA_W      = 16,
  parameter int  NUM_CH      = 4,
  parameter int  SYNC_STAGES = 2,
  parameter int  TIMEOUT_CYC = 1023,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        host_data_in,
  input  logic              host_strobe,
  output logic [7:0]        host_data_out,
  output logic              host_ack,
  output logic [CH_W-1:0]   ch_sel,
  output logic              ch_wr_valid,
  output logic [DATA_W-1:0] ch_wr_data,
  input  logic              ch_wr_ready,
  output logic              ch_rd_req,
  input  logic              ch_rd_valid,
  input  logic [DATA_W-1:0] ch_rd_data,
  output logic              busy,
  output logic [ERR_W-1:0]  err
);

  localparam int               NB    = DATA_W / 8;
  localparam int               CNT_W = $clog2(NB) + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NB - 1);

  logic              byte_pulse;
  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
  logic              bad_q, bad_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] wr_word_q, wr_word_d;
  logic [DATA_W-1:0] rd_word_q, rd_word_d;
  logic [7:0]        dout_q, dout_d;
  logic              ack_q, ack_d;
  logic              req_sent_q, req_sent_d;
  logic [ERR_W-1:0]  err_q, err_d;

  tt_strobe_sync #(
    .STAGES(SYNC_STAGES)
  ) u_strobe_sync (
    .clk     (clk),
    .rst     (rst),
    .async_in(host_strobe),
    .pulse   (byte_pulse)
  );

`ifdef TT_BYTE_BRIDGE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  // Timeout logic is not built; the parameter only keeps the interface identical.
  if (TIMEOUT_CYC < 0) begin : g_tmo_unused
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ch_sel_q   <= '0;
      bad_q      <= 1'b0;
      cnt_q      <= '0;
      wr_word_q  <= '0;
      rd_word_q  <= '0;
      dout_q     <= '0;
      ack_q      <= 1'b0;
      req_sent_q <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      ch_sel_q   <= ch_sel_d;
      bad_q      <= bad_d;
      cnt_q      <= cnt_d;
      wr_word_q  <= wr_word_d;
      rd_word_q  <= rd_word_d;
      dout_q     <= dout_d;
      ack_q      <= ack_d;
      req_sent_q <= req_sent_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_sel_d   = ch_sel_q;
    bad_d      = bad_q;
    cnt_d      = cnt_q;
    wr_word_d  = wr_word_q;
    rd_word_d  = rd_word_q;
    dout_d     = dout_q;
    ack_d      = ack_q;
    req_sent_d = req_sent_q;
    err_d      = err_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (byte_pulse) begin
          ch_sel_d   = host_data_in[CH_W-1:0];
          bad_d      = int'(host_data_in[CMD_CH_MSB:0]) >= NUM_CH;
          req_sent_d = 1'b0;
          ack_d      = ~ack_q;
          if (bad_d) err_d[ERR_BADCH] = 1'b1;
          state_d = host_data_in[CMD_RD_BIT] ? ST_RREQ : ST_WDATA;
        end
      end

      ST_WDATA: begin
        if (byte_pulse) begin
          wr_word_d[8*cnt_q +: 8] = host_data_in;
          ack_d = ~ack_q;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = bad_q ? ST_IDLE : ST_WAIT_WR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_WAIT_WR: begin
        if (byte_pulse) err_d[ERR_OVR] = 1'b1;
        if (ch_wr_ready) state_d = ST_IDLE;
      end

      // A bad channel never issues the request and reads back all ones.
      ST_RREQ: begin
        req_sent_d = 1'b1;
        if (byte_pulse) err_d[ERR_OVR] = 1'b1;
        if (bad_q || ch_rd_valid) begin
          rd_word_d = bad_q ? '1 : ch_rd_data;
          dout_d    = rd_word_d[7:0];
          ack_d     = ~ack_q;
          if (NB == 1) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = ST_RDATA;
          end
        end
      end

      // The host byte that presents the last data byte also closes the frame.
      ST_RDATA: begin
        if (byte_pulse) begin
          dout_d = rd_word_q[8*cnt_q +: 8];
          ack_d  = ~ack_q;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

`ifdef TT_BYTE_BRIDGE_TIMEOUT_EN
    tmo_d = '0;
    if ((state_q == ST_WDATA || state_q == ST_RDATA) && !byte_pulse) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYC)) begin
        state_d        = ST_IDLE;
        cnt_d          = '0;
        err_d[ERR_TMO] = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
  end

  assign host_data_out = dout_q;
  assign host_ack      = ack_q;
  assign ch_sel        = ch_sel_q;
  assign ch_wr_valid   = (state_q == ST_WAIT_WR);
  assign ch_wr_data    = wr_word_q;
  assign ch_rd_req     = (state_q == ST_RREQ) && !req_sent_q && !bad_q;
  assign busy          = (state_q != ST_IDLE);
  assign err           = err_q;

endmodule

// File: tb/tb_tt_byte_bridge.sv
// Self-checking bench for tt_byte_bridge: table of write/read frames plus overrun, reset and timeout sequences.
// Build option: TT_BYTE_BRIDGE_TIMEOUT_EN selects the timeout expectations.
module tb_tt_byte_bridge;
  import tt_bridge_pkg::*;

  localparam int DATA_W = 16;
  localparam int NUM_CH = 4;
  localparam int SYNC   = 2;
  localparam int TMO    = 15;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        host_data_in;
  logic              host_strobe;
  logic [7:0]        host_data_out;
  logic              host_ack;
  logic [CH_W-1:0]   ch_sel;
  logic              ch_wr_valid;
  logic [DATA_W-1:0] ch_wr_data;
  logic              ch_wr_ready;
  logic              ch_rd_req;
  logic              ch_rd_valid;
  logic [DATA_W-1:0] ch_rd_data;
  logic              busy;
  logic [ERR_W-1:0]  err;

  tt_byte_bridge #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .host_data_in(host_data_in), .host_strobe(host_strobe),
    .host_data_out(host_data_out), .host_ack(host_ack), .ch_sel(ch_sel),
    .ch_wr_valid(ch_wr_valid), .ch_wr_data(ch_wr_data), .ch_wr_ready(ch_wr_ready),
    .ch_rd_req(ch_rd_req), .ch_rd_valid(ch_rd_valid), .ch_rd_data(ch_rd_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        bad;
    logic [7:0]  cmd;
    logic [15:0] word;
    logic [1:0]  exp_err;
  } vec_t;

  typedef struct {
    logic [CH_W-1:0] sel;
    logic [15:0]     data;
  } wr_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          ack_cnt  = 0;
  int          wr_seen  = 0;
  int          rd_req_cnt = 0;
  int          stray_req  = 0;
  int          stray_done = 0;
  logic        ack_prev = 1'b0;
  logic [15:0] mem [NUM_CH];
  wr_t         wr_exp_q[$];
  logic [7:0]  rd_exp_q[$];
  wr_t         wr_e;
  vec_t        vecs[7];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    host_data_in = b;
    host_strobe  = 1'b1;
    repeat (4) step();
    host_strobe = 1'b0;
    repeat (4) step();
  endtask

  task automatic wait_ack(input int target, input string name);
    int k = 0;
    while (ack_cnt < target && k < 40) begin
      @(negedge clk);
      k++;
    end
    checkOutput(name, 64'(ack_cnt), 64'(target));
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    @(negedge clk);
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    checkOutput(name, 64'(busy), 64'(0));
  endtask

  // Host ack toggle counter and core-side write monitor with scoreboard.
  always @(negedge clk) begin
    if (!rst && host_ack != ack_prev) ack_cnt++;
    ack_prev = host_ack;
    if (!rst && ch_rd_req) rd_req_cnt++;
    if (!rst && ch_wr_valid && ch_wr_ready) begin
      wr_seen++;
      mem[ch_sel] = ch_wr_data;
      checkOutput("wr_expected_pending", 64'(wr_exp_q.size() != 0), 64'(1));
      if (wr_exp_q.size() != 0) begin
        wr_e = wr_exp_q.pop_front();
        checkOutput("wr_sel", 64'(ch_sel), 64'(wr_e.sel));
        checkOutput("wr_data", 64'(ch_wr_data), 64'(wr_e.data));
      end
    end
  end

  // Core read responder: answers a request three cycles later; also injects a stray valid on demand.
  initial begin
    logic [CH_W-1:0] idx;
    ch_rd_valid = 1'b0;
    ch_rd_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst && ch_rd_req) begin
        idx = ch_sel;
        repeat (3) @(posedge clk);
        #2;
        ch_rd_valid = 1'b1;
        ch_rd_data  = mem[idx];
        @(posedge clk);
        #2;
        ch_rd_valid = 1'b0;
        ch_rd_data  = '0;
      end else if (stray_req != stray_done) begin
        @(posedge clk);
        #2;
        ch_rd_valid = 1'b1;
        ch_rd_data  = 16'h4242;
        @(posedge clk);
        #2;
        ch_rd_valid = 1'b0;
        ch_rd_data  = '0;
        stray_done++;
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    int a0 = ack_cnt;
    int w0 = wr_seen;
    int r0 = rd_req_cnt;
    if (!v.rd) begin
      if (!v.bad) wr_exp_q.push_back('{v.cmd[CH_W-1:0], v.word});
      send_byte(v.cmd);
      send_byte(v.word[7:0]);
      send_byte(v.word[15:8]);
      wait_idle("wr_busy_idle");
      checkOutput("wr_ack_toggles", 64'(ack_cnt - a0), 64'(3));
      checkOutput("wr_count", 64'(wr_seen - w0), v.bad ? 64'(0) : 64'(1));
    end else begin
      rd_exp_q.push_back(v.word[7:0]);
      rd_exp_q.push_back(v.word[15:8]);
      send_byte(v.cmd);
      wait_ack(a0 + 2, "rd_ack_byte0");
      @(negedge clk);
      checkOutput("rd_byte0", 64'(host_data_out), 64'(rd_exp_q.pop_front()));
      checkOutput("rd_busy_mid", 64'(busy), 64'(1));
      step();
      send_byte(8'h00);
      wait_ack(a0 + 3, "rd_ack_byte1");
      @(negedge clk);
      checkOutput("rd_byte1", 64'(host_data_out), 64'(rd_exp_q.pop_front()));
      checkOutput("rd_busy_end", 64'(busy), 64'(0));
      checkOutput("rd_req_pulses", 64'(rd_req_cnt - r0), v.bad ? 64'(0) : 64'(1));
      step();
    end
    checkOutput("err_flags", 64'(err[1:0]), 64'(v.exp_err));
  endtask

  task automatic checkReset();
    checkOutput("rst_host_data_out", 64'(host_data_out), 64'(0));
    checkOutput("rst_host_ack", 64'(host_ack), 64'(0));
    checkOutput("rst_ch_sel", 64'(ch_sel), 64'(0));
    checkOutput("rst_ch_wr_valid", 64'(ch_wr_valid), 64'(0));
    checkOutput("rst_ch_wr_data", 64'(ch_wr_data), 64'(0));
    checkOutput("rst_ch_rd_req", 64'(ch_rd_req), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_err", 64'(err), 64'(0));
  endtask

  initial begin
    int a0;
    int w0;
    int r0;
    mem[0] = 16'h0000;
    mem[1] = 16'hBEEF;
    mem[2] = 16'h0000;
    mem[3] = 16'h0000;
    vecs[0] = '{1'b0, 1'b0, 8'h02, 16'h1234, 2'b00};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 16'hA55A, 2'b00};
    vecs[2] = '{1'b1, 1'b0, 8'h81, 16'hBEEF, 2'b00};
    vecs[3] = '{1'b1, 1'b0, 8'h82, 16'h1234, 2'b00};
    vecs[4] = '{1'b1, 1'b0, 8'h80, 16'hA55A, 2'b00};
    vecs[5] = '{1'b0, 1'b1, 8'h05, 16'h7777, 2'b01};
    vecs[6] = '{1'b1, 1'b1, 8'h85, 16'hFFFF, 2'b01};

    rst          = 1'b1;
    host_data_in = 8'h00;
    host_strobe  = 1'b0;
    ch_wr_ready  = 1'b1;
    repeat (3) step();
    @(negedge clk);
    checkReset();
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    // A read-valid outside a read frame must not disturb anything.
    a0 = ack_cnt;
    r0 = rd_req_cnt;
    stray_req++;
    repeat (6) step();
    @(negedge clk);
    checkOutput("stray_ack", 64'(ack_cnt - a0), 64'(0));
    checkOutput("stray_busy", 64'(busy), 64'(0));
    checkOutput("stray_dout", 64'(host_data_out), 64'(8'hFF));
    checkOutput("stray_done", 64'(stray_done), 64'(1));
    step();

    // Backpressure with an overrun strobe while the write waits.
    ch_wr_ready = 1'b0;
    a0 = ack_cnt;
    w0 = wr_seen;
    wr_exp_q.push_back('{2'd3, 16'h1122});
    send_byte(8'h03);
    send_byte(8'h22);
    send_byte(8'h11);
    @(negedge clk);
    checkOutput("bp_wr_valid", 64'(ch_wr_valid), 64'(1));
    checkOutput("bp_wr_data", 64'(ch_wr_data), 64'(16'h1122));
    checkOutput("bp_ch_sel", 64'(ch_sel), 64'(3));
    step();
    send_byte(8'h99);
    @(negedge clk);
    checkOutput("ovr_err", 64'(err[1:0]), 64'(2'b11));
    checkOutput("ovr_ack_toggles", 64'(ack_cnt - a0), 64'(3));
    checkOutput("ovr_no_write_yet", 64'(wr_seen - w0), 64'(0));
    checkOutput("ovr_wr_data_stable", 64'(ch_wr_data), 64'(16'h1122));
    step();
    repeat (6) step();
    ch_wr_ready = 1'b1;
    wait_idle("bp_busy_idle");
    checkOutput("bp_wr_count", 64'(wr_seen - w0), 64'(1));
    step();

    // Reset in the middle of a write frame, then a clean frame.
    w0 = wr_seen;
    send_byte(8'h01);
    rst = 1'b1;
    step();
    @(negedge clk);
    checkReset();
    step();
    rst = 1'b0;
    step();
    wr_exp_q.push_back('{2'd1, 16'h5678});
    send_byte(8'h01);
    send_byte(8'h78);
    send_byte(8'h56);
    wait_idle("post_rst_busy_idle");
    checkOutput("post_rst_wr_count", 64'(wr_seen - w0), 64'(1));
    checkOutput("post_rst_err", 64'(err), 64'(0));
    step();

    // Stalled write frame: aborts with the timeout option, waits forever without it.
    w0 = wr_seen;
    send_byte(8'h00);
    repeat (30) step();
    @(negedge clk);
`ifdef TT_BYTE_BRIDGE_TIMEOUT_EN
    checkOutput("tmo_busy", 64'(busy), 64'(0));
    checkOutput("tmo_err", 64'(err[ERR_TMO]), 64'(1));
    checkOutput("tmo_no_write", 64'(wr_seen - w0), 64'(0));
    step();
`else
    checkOutput("stall_busy", 64'(busy), 64'(1));
    checkOutput("stall_no_write", 64'(wr_seen - w0), 64'(0));
    step();
    wr_exp_q.push_back('{2'd0, 16'hC3C3});
    send_byte(8'hC3);
    send_byte(8'hC3);
    wait_idle("stall_busy_idle");
    checkOutput("stall_wr_count", 64'(wr_seen - w0), 64'(1));
    step();
`endif

    checkOutput("wr_queue_empty", 64'(wr_exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "[TB] global timeout");
  end

endmodule
